// File: rtl/ddr4_pkg.sv
// Shared types for the DDR4 DIMM responder: command, bank-state and error-cause
// encodings plus the RAS/CAS/WE command decoder.
package ddr4_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF,
        CMD_ILLEGAL,
        CMD_DESEL
    } cmd_e;

    typedef enum logic [1:0] {
        BS_IDLE,
        BS_OPENING,
        BS_ACTIVE,
        BS_CLOSING
    } bank_state_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_STATE  = 3'd1,
        ERR_NOT_ACTIVE = 3'd2,
        ERR_REF_OPEN   = 3'd3,
        ERR_ILLEGAL    = 3'd4
    } err_code_e;

    // cmd_bits = {cs_N, ras_N, cas_N, we_N}
    function automatic cmd_e decode_cmd(input logic [3:0] cmd_bits);
        cmd_e c;
        if (cmd_bits[3]) begin
            c = CMD_DESEL;
        end else begin
            case (cmd_bits[2:0])
                3'b011:  c = CMD_ACT;
                3'b101:  c = CMD_RD;
                3'b100:  c = CMD_WR;
                3'b010:  c = CMD_PRE;
                3'b001:  c = CMD_REF;
                3'b111:  c = CMD_NOP;
                default: c = CMD_ILLEGAL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/ddr4_bank_fsm.sv
// One DDR4 bank: IDLE/OPENING/ACTIVE/CLOSING state, latched open row and the
// tRCD/tRP countdown.
module ddr4_bank_fsm
    import ddr4_pkg::*;
#(
    parameter int ROW_BITS = 6,
    parameter int T_RCD    = 3,
    parameter int T_RP     = 3
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                act_i,
    input  logic                pre_i,
    input  logic [ROW_BITS-1:0] row_i,
    output logic                is_idle_o,
    output logic                is_active_o,
    output logic [ROW_BITS-1:0] open_row_o
);

    localparam logic [1:0] S_IDLE    = BS_IDLE;
    localparam logic [1:0] S_OPENING = BS_OPENING;
    localparam logic [1:0] S_ACTIVE  = BS_ACTIVE;
    localparam logic [1:0] S_CLOSING = BS_CLOSING;

    logic [1:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ROW_BITS-1:0] row_q, row_d;

    // The counter is loaded with T-1 so that a command arriving exactly T
    // edges after ACT/PRE already sees the settled state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (act_i) begin
                    row_d   = row_i;
                    cnt_d   = 8'(T_RCD - 1);
                    state_d = (T_RCD <= 1) ? S_ACTIVE : S_OPENING;
                end
            end
            S_OPENING: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (pre_i) begin
                    cnt_d   = 8'(T_RP - 1);
                    state_d = (T_RP <= 1) ? S_IDLE : S_CLOSING;
                end
            end
            default: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    assign is_idle_o   = (state_q == S_IDLE);
    assign is_active_o = (state_q == S_ACTIVE);
    assign open_row_o  = row_q;

endmodule

// File: rtl/ddr4_dimm_responder.sv
// DDR4 DIMM responder: command decode, per-bank FSMs, RD/WR burst sequencing,
// refresh timer and storage. DDR4_RESP_PROTO_CHECK_EN enables err_out/err_code_out.
module ddr4_dimm_responder
    import ddr4_pkg::*;
#(
    parameter int BANKS    = 8,
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 4,
    parameter int DATA_W   = 64,
    parameter int BURST    = 4,
    parameter int T_RCD    = 3,
    parameter int T_CL     = 4,
    parameter int T_RP     = 3,
    parameter int T_RFC    = 12,
    localparam int BANK_W  = $clog2(BANKS),
    localparam int ADDR_W  = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              cs_N_in,
    input  logic              ras_N_in,
    input  logic              cas_N_in,
    input  logic              we_N_in,
    input  logic [BANK_W-1:0] bank_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              err_out
`ifdef DDR4_RESP_PROTO_CHECK_EN
    ,
    output logic [2:0]        err_code_out
`endif
);

    localparam int IDX_W = BANK_W + ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = 8;

    cmd_e                cmd;
    logic [BANKS-1:0]    bank_idle, bank_active;
    logic [ROW_BITS-1:0] open_row [BANKS];
    logic                tgt_idle, tgt_active, all_idle;
    logic                do_act, do_pre, do_rd, do_wr, do_ref;
    logic [COL_BITS-1:0] cmd_base;

    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, ref_cnt_q, ref_cnt_d;
    logic [BANK_W-1:0]   rd_bank_q, rd_bank_d, wr_bank_q, wr_bank_d;
    logic [ROW_BITS-1:0] rd_row_q, rd_row_d, wr_row_q, wr_row_d;
    logic [COL_BITS-1:0] rd_base_q, rd_base_d, wr_base_q, wr_base_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [COL_BITS-1:0] rd_col, wr_col;

    assign cmd        = decode_cmd({cs_N_in, ras_N_in, cas_N_in, we_N_in});
    assign tgt_idle   = bank_idle[bank_in];
    assign tgt_active = bank_active[bank_in];
    assign all_idle   = &bank_idle;
    assign ready_out  = (rd_cnt_q == '0) && (wr_cnt_q == '0) && (ref_cnt_q == '0);
    assign cmd_base   = addr_in[COL_BITS-1:0] & ~COL_BITS'(BURST - 1);

    // PRE on an IDLE bank is accepted but has no effect on the FSM.
    assign do_act = ready_out && (cmd == CMD_ACT) && tgt_idle;
    assign do_pre = ready_out && (cmd == CMD_PRE) && tgt_active;
    assign do_rd  = ready_out && (cmd == CMD_RD)  && tgt_active;
    assign do_wr  = ready_out && (cmd == CMD_WR)  && tgt_active;
    assign do_ref = ready_out && (cmd == CMD_REF) && all_idle;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ddr4_bank_fsm #(
            .ROW_BITS (ROW_BITS),
            .T_RCD    (T_RCD),
            .T_RP     (T_RP)
        ) u_bank (
            .clk         (clk),
            .rst_in      (rst_in),
            .act_i       (do_act && (bank_in == BANK_W'(b))),
            .pre_i       (do_pre && (bank_in == BANK_W'(b))),
            .row_i       (addr_in[ROW_BITS-1:0]),
            .is_idle_o   (bank_idle[b]),
            .is_active_o (bank_active[b]),
            .open_row_o  (open_row[b])
        );
    end

    always_comb begin
        rd_cnt_d  = (rd_cnt_q  != '0) ? rd_cnt_q  - CNT_W'(1) : rd_cnt_q;
        wr_cnt_d  = (wr_cnt_q  != '0) ? wr_cnt_q  - CNT_W'(1) : wr_cnt_q;
        ref_cnt_d = (ref_cnt_q != '0) ? ref_cnt_q - CNT_W'(1) : ref_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_row_d  = rd_row_q;
        rd_base_d = rd_base_q;
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        wr_base_d = wr_base_q;
        if (do_rd) begin
            rd_cnt_d  = CNT_W'(T_CL + BURST);
            rd_bank_d = bank_in;
            rd_row_d  = open_row[bank_in];
            rd_base_d = cmd_base;
        end
        if (do_wr) begin
            wr_cnt_d  = CNT_W'(BURST);
            wr_bank_d = bank_in;
            wr_row_d  = open_row[bank_in];
            wr_base_d = cmd_base;
        end
        if (do_ref) ref_cnt_d = CNT_W'(T_RFC);
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            ref_cnt_q <= '0;
            rd_bank_q <= '0;
            rd_row_q  <= '0;
            rd_base_q <= '0;
            wr_bank_q <= '0;
            wr_row_q  <= '0;
            wr_base_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_row_q  <= rd_row_d;
            rd_base_q <= rd_base_d;
            wr_bank_q <= wr_bank_d;
            wr_row_q  <= wr_row_d;
            wr_base_q <= wr_base_d;
        end
    end

    // Word index within the burst is derived from the remaining count.
    assign wr_col    = wr_base_q | COL_BITS'(BURST - int'(wr_cnt_q));
    assign rd_col    = rd_base_q | COL_BITS'(BURST - int'(rd_cnt_q));
    assign valid_out = (rd_cnt_q != '0) && (rd_cnt_q <= CNT_W'(BURST));
    assign rdata_out = valid_out ? mem[{rd_bank_q, rd_row_q, rd_col}] : '0;

    always_ff @(posedge clk) begin
        if (wr_cnt_q != '0) mem[{wr_bank_q, wr_row_q, wr_col}] <= wdata_in;
    end

`ifdef DDR4_RESP_PROTO_CHECK_EN
    err_code_e  err_code_d;
    logic       err_q;
    logic [2:0] err_code_q;

    always_comb begin
        err_code_d = ERR_NONE;
        if (ready_out) begin
            case (cmd)
                CMD_ACT:        if (!tgt_idle)                 err_code_d = ERR_BAD_STATE;
                CMD_PRE:        if (!tgt_idle && !tgt_active)  err_code_d = ERR_BAD_STATE;
                CMD_RD, CMD_WR: if (!tgt_active)               err_code_d = ERR_NOT_ACTIVE;
                CMD_REF:        if (!all_idle)                 err_code_d = ERR_REF_OPEN;
                CMD_ILLEGAL:                                   err_code_d = ERR_ILLEGAL;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            err_q <= (err_code_d != ERR_NONE);
            if (err_code_d != ERR_NONE) err_code_q <= err_code_d;
        end
    end

    assign err_out      = err_q;
    assign err_code_out = err_code_q;
`else
    assign err_out = 1'b0;
`endif

endmodule
